// File: rtl/ofm_addr_controller.sv
// OFM write-address generator: streams one tile of systolic-array results into
// the output feature-map memory, filter-outer / pixel-inner, then advances the tile.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for start; tile_base holds the next tile's origin
//   WRITE     | one address per valid word; stalls while data_valid is low
//   NEXT_TILE | one-cycle tile_base advance, layer wrap detection
module ofm_addr_controller #(
  parameter int OFM_SIZE   = 416,
  parameter int NUM_FILTER = 16,
  parameter int TILE_WIDTH = 16,
  parameter int ADDR_WIDTH = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  data_valid,
  output logic [ADDR_WIDTH-1:0] ofm_addr,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  tile_done,
  output logic                  layer_done
);

  localparam int PIX_W = (TILE_WIDTH > 1) ? $clog2(TILE_WIDTH) : 1;
  localparam int FIL_W = (NUM_FILTER > 1) ? $clog2(NUM_FILTER) : 1;

  // Plane stride is an elaboration-time constant, so the datapath stays adders only.
  localparam logic [ADDR_WIDTH-1:0] PLANE_A  = ADDR_WIDTH'(OFM_SIZE * OFM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] TILE_A   = ADDR_WIDTH'(TILE_WIDTH);
  localparam logic [PIX_W-1:0]      PIX_LAST = PIX_W'(TILE_WIDTH - 1);
  localparam logic [FIL_W-1:0]      FIL_LAST = FIL_W'(NUM_FILTER - 1);

  typedef enum logic [1:0] {IDLE, WRITE, NEXT_TILE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   tile_base;
  logic [ADDR_WIDTH-1:0]   filter_base;
  logic [PIX_W-1:0]        pixel;
  logic [FIL_W-1:0]        filter;
  logic [ADDR_WIDTH-1:0]   base_next;
  logic [ADDR_WIDTH-1:0]   plane_next;

  assign base_next  = tile_base + TILE_A;
  assign plane_next = filter_base + PLANE_A;

  assign wr_en = (state == WRITE) && data_valid;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ofm_addr    <= '0;
      tile_base   <= '0;
      filter_base <= '0;
      pixel       <= '0;
      filter      <= '0;
      tile_done   <= 1'b0;
      layer_done  <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ofm_addr    <= tile_base;
            filter_base <= tile_base;
            pixel       <= '0;
            filter      <= '0;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (data_valid) begin
            if (pixel != PIX_LAST) begin
              ofm_addr <= ofm_addr + ADDR_WIDTH'(1);
              pixel    <= pixel + PIX_W'(1);
            end else if (filter != FIL_LAST) begin
              filter_base <= plane_next;
              ofm_addr    <= plane_next;
              pixel       <= '0;
              filter      <= filter + FIL_W'(1);
            end else begin
              tile_done <= 1'b1;
              state     <= NEXT_TILE;
            end
          end
        end
        NEXT_TILE: begin
          tile_done <= 1'b0;
          // Last tile of the plane: wrap to the layer origin and flag the layer.
          if (base_next == PLANE_A) begin
            tile_base  <= '0;
            layer_done <= 1'b1;
          end else begin
            tile_base <= base_next;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_addr_controller.sv
// Randomized directed bench for ofm_addr_controller: a default-size instance
// for address/latency checks and a tiny instance that can reach the layer wrap.
module tb_ofm_addr_controller;

  localparam logic [31:0] MASK = 32'h003F_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, dv_a, start_b, dv_b;
  logic [21:0] addr_a, addr_b;
  logic wr_a, busy_a, td_a, ld_a;
  logic wr_b, busy_b, td_b, ld_b;

  int checks = 0;
  int errors = 0;
  int unsigned base [2];

  always #5 clk = ~clk;

  ofm_addr_controller dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .data_valid(dv_a),
    .ofm_addr(addr_a), .wr_en(wr_a), .busy(busy_a),
    .tile_done(td_a), .layer_done(ld_a)
  );

  ofm_addr_controller #(
    .OFM_SIZE(8), .NUM_FILTER(2), .TILE_WIDTH(4), .ADDR_WIDTH(22)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .data_valid(dv_b),
    .ofm_addr(addr_b), .wr_en(wr_b), .busy(busy_b),
    .tile_done(td_b), .layer_done(ld_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned plane_of(input int d);
    return d ? 32'd64 : 32'd173056;
  endfunction
  function automatic int tw_of(input int d);
    return d ? 4 : 16;
  endfunction
  function automatic int nf_of(input int d);
    return d ? 2 : 16;
  endfunction

  // k-th write of a tile: filter k/tw, pixel k%tw
  function automatic logic [31:0] exp_addr(input int d, input int unsigned b, input int k);
    return ((k / tw_of(d)) * plane_of(d) + b + (k % tw_of(d))) & MASK;
  endfunction

  task automatic drive(input int d, input logic s, input logic v);
    if (d == 1) begin start_b = s; dv_b = v; end
    else begin start_a = s; dv_a = v; end
  endtask

  task automatic sample(input int d, output logic b, output logic w, output logic [31:0] a,
                        output logic t, output logic l);
    if (d == 1) begin b = busy_b; w = wr_b; a = 32'(addr_b); t = td_b; l = ld_b; end
    else begin b = busy_a; w = wr_a; a = 32'(addr_a); t = td_a; l = ld_a; end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, {addr_b, addr_a}, 0);
    chk({tag, "_flags"}, {wr_a, busy_a, td_a, ld_a, wr_b, busy_b, td_b, ld_b}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    base[0] = 0;
    base[1] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One full tile. mode 0: data_valid constant 1, 1: toggling 1,0,.., 2: random.
  task automatic run_tile(input int d, input int mode, output logic [31:0] first_a,
                          output logic [31:0] last_a);
    logic [31:0] exp_q [$];
    logic b, w, t, l, v, wrap, done;
    logic [31:0] a;
    int n, idx, td_cyc, busy_cnt;
    n = nf_of(d) * tw_of(d);
    for (int k = 0; k < n; k++) exp_q.push_back(exp_addr(d, base[d], k));
    wrap = ((base[d] + tw_of(d)) == plane_of(d));
    idx = 0; td_cyc = 0; busy_cnt = 0; done = 1'b0;
    first_a = '1; last_a = '1;
    drive(d, 1'b1, 1'b0);
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 4 * n + 8 && !done; cyc++) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      drive(d, 1'b0, v);
      @(negedge clk);
      sample(d, b, w, a, t, l);
      if (cyc == 1) begin
        chk("first_addr", a, exp_q[0]);
        first_a = a;
      end
      if (!b) begin
        chk("layer_done_after_tile", l, wrap);
        chk("idle_after_tile_done", cyc - 1, td_cyc);
        done = 1'b1;
      end else begin
        busy_cnt++;
        chk("layer_done_low", l, 0);
        chk("wr_en", w, v && !t);
        if (w) begin
          chk("wr_addr", a, (idx < n) ? exp_q[idx] : 32'hFFFF_FFFF);
          last_a = a;
          idx++;
        end else if (t) begin
          chk("writes_per_tile", idx, n);
          td_cyc = cyc;
        end else begin
          chk("stall_hold", a, (idx < n) ? exp_q[idx] : 32'hFFFF_FFFF);
        end
      end
      @(posedge clk); #1;
    end
    chk("tile_timeout", done, 1);
    if (mode == 0) chk("tile_done_cycle", td_cyc, n + 1);
    chk("busy_cycles", busy_cnt, td_cyc);
    base[d] = wrap ? 0 : base[d] + tw_of(d);
    drive(d, 1'b0, 1'b0);
    @(negedge clk);
    sample(d, b, w, a, t, l);
    chk("pulses_cleared", {b, t, l}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] f, la;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    base[0] = 0;
    base[1] = 0;
    #1 check_all_zero("reset_async");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_all_zero("idle_no_start");
    end
    @(posedge clk); #1;

    run_tile(0, 0, f, la);
    chk("t0_first", f, 0);
    chk("t0_last", la, 2595855);

    do_reset();
    run_tile(0, 1, f, la);
    chk("toggle_first", f, 0);
    chk("toggle_last", la, 2595855);

    run_tile(0, 0, f, la);
    chk("second_first", f, 16);
    chk("second_last", la, 2595871);

    run_tile(0, 2, f, la);
    chk("random_first", f, 32);

    // start mid-WRITE is ignored, then reset aborts the tile
    drive(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      drive(0, k == 8, 1'b1);
      @(negedge clk);
      chk("mid_write_addr", 32'(addr_a), exp_addr(0, base[0], k));
      chk("mid_write_wr", wr_a, 1);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1 check_all_zero("reset_mid_write");
    base[0] = 0;
    base[1] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_wr_after_reset", {wr_a, busy_a, 22'(addr_a)}, 0);
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0);
    run_tile(0, 2, f, la);
    chk("restart_first", f, 0);

    // small instance: full layer of 16 tiles plus the wrapped first tile
    for (int t = 0; t < 17; t++) begin
      run_tile(1, 2, f, la);
      if (t == 15) chk("last_tile_first", f, 60);
      if (t == 16) chk("wrapped_first", f, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
